// File: rtl/rolagem_mensagem_if.sv
// rolagem_mensagem_if -- panel-side bundle of the frame generator.
//   ch1, ch0 : mode switches (raw, asynchronous to clk)
//   ru0..ru4 : row words for rows 0..4, bit 6 = leftmost column C0
//   pos      : current window start column (debug/verification)
// modport slave  : frame generator side (reads switches, drives rows)
// modport master : panel/controller side (drives switches, reads rows)
interface rolagem_mensagem_if;
  logic       ch1;
  logic       ch0;
  logic [6:0] ru0;
  logic [6:0] ru1;
  logic [6:0] ru2;
  logic [6:0] ru3;
  logic [6:0] ru4;
  logic [4:0] pos;

  modport slave (
    input  ch1, ch0,
    output ru0, ru1, ru2, ru3, ru4, pos
  );

  modport master (
    output ch1, ch0,
    input  ru0, ru1, ru2, ru3, ru4, pos
  );
endinterface

// File: rtl/rolagem_mensagem.sv
// rolagem_mensagem -- frame generator for the 5x7 LED dot-matrix panel.
// Shows a fixed message (parameter ROM MSG, 5 bits per column) as blank,
// static, scrolling or blinking depending on the two panel switches.
//   clk : system clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : rolagem_mensagem_if.slave (ch1/ch0 in; ru0..ru4, pos out)
module rolagem_mensagem #(
  parameter int                   MSG_LEN  = 24,
  parameter int                   STEP_DIV = 12_500_000,
  parameter logic [5*MSG_LEN-1:0] MSG      = {(5*MSG_LEN){1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  rolagem_mensagem_if.slave    bus
);

  localparam int              PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0]   PRE_ONE  = PW'(1);
  localparam logic [4:0]      POS_LAST = 5'(MSG_LEN - 1);
  localparam logic [5:0]      LEN6     = 6'(MSG_LEN);

  typedef enum logic [1:0] {
    BLANK  = 2'b00,
    STATIC = 2'b01,
    SCROLL = 2'b10,
    BLINK  = 2'b11
  } modeT;

  // Seven-column window starting at column 'start'; row r, bit (6-k) = bit r
  // of message column (start + k) mod MSG_LEN. One subtraction suffices
  // because start < MSG_LEN and k <= 6 < MSG_LEN.
  function automatic logic [4:0][6:0] windowRows(input logic [4:0] start);
    logic [5:0]      idx;
    logic [4:0]      col;
    logic [4:0][6:0] rows;
    rows = {5{7'h00}};
    for (int k = 0; k < 7; k++) begin
      idx = {1'b0, start} + 6'(k);
      if (idx >= LEN6) begin
        idx = idx - LEN6;
      end else begin
        idx = idx;
      end
      col = 5'(MSG >> (5 * idx));
      for (int r = 0; r < 5; r++) begin
        rows[r][6-k] = col[r];
      end
    end
    return rows;
  endfunction

  logic [1:0]      chS1;
  logic [1:0]      chS2;
  modeT            modo;
  logic [PW-1:0]   preCnt;
  logic [4:0]      pos;
  logic            hidden;
  logic [4:0][6:0] rowR;

  modeT            modeNext;
  logic            modeChg;
  logic            tick;
  logic [PW-1:0]   preNext;
  logic [4:0]      posNext;
  logic            hiddenNext;
  logic [4:0][6:0] window;
  logic [4:0][6:0] rowNext;

  // Next-state and next-output logic; rows are built from the next-state
  // values so the registered outputs always match the registered pos/mode.
  always_comb begin
    modeNext   = modeT'(chS2);
    modeChg    = (modeNext != modo);
    tick       = (preCnt == PRE_LAST);
    preNext    = preCnt;
    posNext    = pos;
    hiddenNext = hidden;
    if (modeChg) begin
      // a tick landing on the mode-change edge is dropped
      preNext    = {PW{1'b0}};
      posNext    = 5'd0;
      hiddenNext = 1'b0;
    end else begin
      preNext = tick ? {PW{1'b0}} : preCnt + PRE_ONE;
      case (modo)
        SCROLL: begin
          hiddenNext = 1'b0;
          if (tick) begin
            posNext = (pos == POS_LAST) ? 5'd0 : pos + 5'd1;
          end else begin
            posNext = pos;
          end
        end
        BLINK: begin
          posNext = 5'd0;
          if (tick) begin
            hiddenNext = ~hidden;
          end else begin
            hiddenNext = hidden;
          end
        end
        default: begin
          posNext    = 5'd0;
          hiddenNext = 1'b0;
        end
      endcase
    end

    window  = windowRows(posNext);
    rowNext = window;
    case (modeNext)
      BLANK:   rowNext = {5{7'h00}};
      BLINK: begin
        if (hiddenNext) begin
          rowNext = {5{7'h00}};
        end else begin
          rowNext = window;
        end
      end
      default: rowNext = window;
    endcase
  end

  // Switch synchroniser, mode/prescaler/window state and registered rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      chS1   <= 2'b00;
      chS2   <= 2'b00;
      modo   <= BLANK;
      preCnt <= {PW{1'b0}};
      pos    <= 5'd0;
      hidden <= 1'b0;
      rowR   <= {5{7'h00}};
    end else begin
      chS1   <= {bus.ch1, bus.ch0};
      chS2   <= chS1;
      modo   <= modeNext;
      preCnt <= preNext;
      pos    <= posNext;
      hidden <= hiddenNext;
      rowR   <= rowNext;
    end
  end

  assign bus.ru0 = rowR[0];
  assign bus.ru1 = rowR[1];
  assign bus.ru2 = rowR[2];
  assign bus.ru3 = rowR[3];
  assign bus.ru4 = rowR[4];
  assign bus.pos = pos;

endmodule

// File: tb/tb_rolagem_mensagem.sv
// tb_rolagem_mensagem -- scoreboard bench for rolagem_mensagem.
// MSG_LEN = 24, STEP_DIV = 4, message column i holds the value i.
// The stimulus process pushes hand-computed expectations tagged with the
// cycle on which they must hold; the monitor pops and compares on negedges.
module tb_rolagem_mensagem;

  localparam int MSG_LEN  = 24;
  localparam int STEP_DIV = 4;
  localparam int END_CYC  = 190;

  function automatic logic [5*MSG_LEN-1:0] mkMsg();
    logic [5*MSG_LEN-1:0] m;
    m = {(5*MSG_LEN){1'b0}};
    for (int i = 0; i < MSG_LEN; i++) m[5*i +: 5] = 5'(i);
    return m;
  endfunction

  // row words packed {ru4, ru3, ru2, ru1, ru0}
  localparam logic [34:0] Z   = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  localparam logic [34:0] W0  = {7'h00, 7'h00, 7'h07, 7'h19, 7'h2A};
  localparam logic [34:0] W1  = {7'h00, 7'h00, 7'h0F, 7'h33, 7'h55};
  localparam logic [34:0] W23 = {7'h40, 7'h00, 7'h43, 7'h4C, 7'h55};

  typedef struct {
    int          cyc;
    logic [34:0] ru;
    logic        chkRu;
    logic [4:0]  pos;
    string       tag;
  } expT;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  expT  sbQ[$];

  rolagem_mensagem_if busIf ();

  rolagem_mensagem #(
    .MSG_LEN (MSG_LEN),
    .STEP_DIV(STEP_DIV),
    .MSG     (mkMsg())
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [34:0] ru, input logic chkRu,
                      input logic [4:0] p, input string tag);
    expT e;
    e.cyc = c; e.ru = ru; e.chkRu = chkRu; e.pos = p; e.tag = tag;
    sbQ.push_back(e);
  endtask

  task automatic pushRange(input int c0, input int c1, input logic [34:0] ru,
                           input logic [4:0] p, input string tag);
    for (int c = c0; c <= c1; c++) push(c, ru, 1'b1, p, tag);
  endtask

  task automatic stepTo(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stimulus: drives rst/switches and records what must be seen on each cycle.
  initial begin
    logic [34:0] w;
    rst = 1'b1;
    busIf.ch1 = 1'b1;
    busIf.ch0 = 1'b1;

    // reset with ch = 11, then BLINK entry three cycles after release
    pushRange(1, 3, Z, 5'd0, "reset");
    stepTo(3);
    rst = 1'b0;
    pushRange(4, 5, Z, 5'd0, "blank_lat");
    pushRange(6, 9, W0, 5'd0, "blink_vis");
    pushRange(10, 13, Z, 5'd0, "blink_hid");
    pushRange(14, 17, W0, 5'd0, "blink_vis2");
    push(18, Z, 1'b1, 5'd0, "blink_hid2");

    // STATIC: steady window for 40 cycles
    stepTo(18);
    busIf.ch1 = 1'b0;
    busIf.ch0 = 1'b1;
    pushRange(19, 20, Z, 5'd0, "static_lat");
    pushRange(21, 60, W0, 5'd0, "static");

    // SCROLL: entry at cycle 63, one step every 4 cycles, wrap after 23
    stepTo(60);
    busIf.ch1 = 1'b1;
    busIf.ch0 = 1'b0;
    pushRange(61, 62, W0, 5'd0, "scroll_lat");
    for (int k = 0; k <= 24; k++) begin
      w = (k == 1) ? W1 : (k == 23) ? W23 : W0;
      push(63 + 4*k, w, (k == 0 || k == 1 || k == 23 || k == 24),
           5'(k % 24), "scroll_step");
      push(66 + 4*k, w, (k == 0 || k == 1 || k == 23 || k == 24),
           5'(k % 24), "scroll_hold");
    end
    pushRange(163, 166, W1, 5'd1, "scroll_pre");
    push(167, W0, 1'b1, 5'd0, "chg_on_tick");

    // 10 -> 01 lands exactly on the tick edge 167
    stepTo(164);
    busIf.ch1 = 1'b0;
    busIf.ch0 = 1'b1;

    // back to SCROLL, then reset mid-scroll
    stepTo(168);
    busIf.ch1 = 1'b1;
    busIf.ch0 = 1'b0;
    pushRange(168, 170, W0, 5'd0, "static2");
    pushRange(171, 174, W0, 5'd0, "scroll2_entry");
    pushRange(175, 178, W1, 5'd1, "scroll2_step");
    pushRange(179, 181, Z, 5'd0, "mid_reset");
    pushRange(182, 185, W0, 5'd0, "post_reset");
    push(186, W1, 1'b1, 5'd1, "post_reset_tick");
    stepTo(178);
    rst = 1'b1;
    stepTo(179);
    rst = 1'b0;
  end

  // Monitor: compare the queue head on its cycle, flag stale entries, and
  // close the run with the summary once the cycle budget is spent.
  always @(negedge clk) begin
    expT e;
    logic [34:0] got;
    got = {busIf.ru4, busIf.ru3, busIf.ru2, busIf.ru1, busIf.ru0};
    while (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
      e = sbQ.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s missed cyc=%0d", e.tag, e.cyc);
    end
    if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
      e = sbQ.pop_front();
      if (e.chkRu) begin
        checks = checks + 1;
        if (got !== e.ru) begin
          errors = errors + 1;
          $display("FAIL %s ru cyc=%0d got=%h want=%h", e.tag, cyc, got, e.ru);
        end
      end
      checks = checks + 1;
      if (busIf.pos !== e.pos) begin
        errors = errors + 1;
        $display("FAIL %s pos cyc=%0d got=%0d want=%0d", e.tag, cyc, busIf.pos, e.pos);
      end
    end
    if (cyc >= END_CYC) begin
      while (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s unchecked cyc=%0d", e.tag, e.cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

endmodule

// File: doc/rolagem_mensagem.md
# rolagem_mensagem

Frame generator for the 5×7 LED dot-matrix panel: produces the five 7-bit row words (ru0..ru4) that the row-register bank loads and the column/row scan circuitry displays. Selects the display mode from the two panel switches (ch1, ch0) and shows a fixed message held in a parameter ROM as blank, static, scrolling or blinking. Sits directly upstream of the register bank; its outputs replace the hard-wired row patterns.

## Interface
- MSG_LEN, 24: message length in columns; legal range 7..32.
- STEP_DIV, 12_500_000: clk cycles per animation step (4 steps/s at 50 MHz); minimum 2.
- MSG, 120'h0: message ROM, 5 bits per column, column i at bits [5i+4:5i], bit r of a column = row r (1 = LED on). Width is 5*MSG_LEN.
- clk  input  1  system clock; one clock domain; all state updates on rising edge.
- rst  input  1  reset; synchronous and active-high.
- ch1  input  1  mode switch, MSB; asynchronous to clk.
- ch0  input  1  mode switch, LSB; asynchronous to clk.
- ru0..ru4  output  7 each  row words for rows 0..4; bit 6 = column C0 (leftmost), bit 0 = C6.
- pos  output  5  current window start column (debug/verification); upper bits 0 when MSG_LEN < 32.

## Operation
- Switch synchroniser: ch1/ch0 each pass two flops (s1, s2). Mode = {ch1_s2, ch0_s2}.
- State register `modo` holds one of: BLANK (00), STATIC (01), SCROLL (10), BLINK (11); loaded from synchronised mode each cycle.
- Mode change (synchronised value differs from `modo`): `modo` takes new value; step prescaler cleared to 0; pos cleared to 0; blink phase set to visible. Any tick in that same cycle is discarded.
- Step prescaler: counts 0..STEP_DIV-1, wraps; `tick` asserted (internal, 1 cycle) when count = STEP_DIV-1. Free-running in all modes.
- Window: window column k (k = 0..6) = MSG column (pos + k) mod MSG_LEN; ru_r bit (6-k) = bit r of that column.
- BLANK: all ru = 0; pos held 0.
- STATIC: window at pos = 0; ticks ignored.
- SCROLL: on each tick pos ← pos+1, wrapping MSG_LEN-1 → 0. Content moves one column left per step.
- BLINK: pos held 0; each tick toggles blink phase; visible phase shows STATIC window, hidden phase drives all ru = 0.
- Outputs registered: ru0..ru4 computed from next-state pos/mode/phase and loaded on the same edge, so outputs never show a partial window.
- Modulo arithmetic: (pos + k) computed with width 6, subtract MSG_LEN once if ≥ MSG_LEN; no other reduction needed since pos < MSG_LEN and k ≤ 6.

## Timing
- Reset: on the rising edge with rst = 1: s1, s2 = 0; modo = BLANK; prescaler = 0; pos = 0; blink phase = visible; ru0..ru4 = 0. Held while rst = 1. rst overrides mode change and tick in the same cycle.
- Reset mid-scroll: next edge clears everything; after rst falls, first tick arrives STEP_DIV cycles later.
- Switch latency: value stable before edge E1 → s1 at E1, s2 at E2, modo and outputs updated at E3 (3 cycles).
- SCROLL: pos and outputs change on the edge where tick = 1; first step STEP_DIV cycles after the mode-change edge.
- BLINK: first hide at STEP_DIV cycles after mode entry; period 2*STEP_DIV.
- Switch glitch shorter than one cycle may be missed or taken; any change reaching s2 is a full mode change.

## Test plan
Bench settings: MSG_LEN = 24, STEP_DIV = 4, MSG column i = i[4:0].
- rst high 3 cycles, ch = 11 → ru0..ru4 = 0, pos = 0 throughout; after rst low, mode BLINK taken 3 cycles later.
- ch = 01 → 3 cycles later ru0 = 7'h2A, ru1 = 7'h19, ru2 = 7'h07, ru3 = ru4 = 0; unchanged for 40 cycles.
- ch = 10 → pos 0 at entry; after first tick (4 cycles) pos = 1, ru0 = 7'h55, ru2 = 7'h0F, ru3 = 0; pos steps every 4 cycles.
- SCROLL wrap: after 23 ticks pos = 23, ru0 = 7'h55, ru4 = 7'h40; next tick pos = 0, ru0 = 7'h2A.
- ch = 11 → static window (ru0 = 7'h2A) for 4 cycles, all zero for 4, visible again; pos stays 0.
- ch 10 → 01 on the cycle a tick would occur → pos = 0, prescaler restarts, ru0 = 7'h2A; assert rst mid-scroll → all outputs 0 on the next edge.
